// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage: valid/ready handshake with a two-entry skid buffer
// so in_ready depends only on register state; supports flush and lane bubbles.
module if_id_skid_stage #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_en,
    input  logic [LANES*PC_W-1:0]     in_pc,
    input  logic [LANES*INST_W-1:0]   in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_en,
    output logic [LANES*PC_W-1:0]     out_pc,
    output logic [LANES*INST_W-1:0]   out_inst,
    output logic [1:0]                occ,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned PCV_W  = LANES * PC_W;
    localparam int unsigned INSV_W = LANES * INST_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid, s_valid, m_valid_nxt, s_valid_nxt;
    logic [LANES-1:0]  m_en, s_en, m_en_nxt, s_en_nxt;
    logic [PCV_W-1:0]  m_pc, s_pc, m_pc_nxt, s_pc_nxt;
    logic [INSV_W-1:0] m_inst, s_inst, m_inst_nxt, s_inst_nxt;
    logic [PCV_W-1:0]  san_pc;
    logic [INSV_W-1:0] san_inst;
    logic [CNT_W-1:0]  stall_q;
    logic              acc;

    // Disabled lanes are captured as all-zero NOP bubbles
    for (genvar i = 0; i < LANES; i++) begin : g_san
        assign san_pc[i*PC_W +: PC_W]       = in_lane_en[i] ? in_pc[i*PC_W +: PC_W] : '0;
        assign san_inst[i*INST_W +: INST_W] = in_lane_en[i] ? in_inst[i*INST_W +: INST_W] : '0;
    end

    assign acc = in_valid & ~s_valid;

    // Next-state selection for main and skid entries
    always_comb begin
        m_valid_nxt = m_valid;
        m_en_nxt    = m_en;
        m_pc_nxt    = m_pc;
        m_inst_nxt  = m_inst;
        s_valid_nxt = s_valid;
        s_en_nxt    = s_en;
        s_pc_nxt    = s_pc;
        s_inst_nxt  = s_inst;
        if (flush) begin
            m_valid_nxt = 1'b0;
            m_en_nxt    = '0;
            m_pc_nxt    = '0;
            m_inst_nxt  = '0;
            s_valid_nxt = 1'b0;
            s_en_nxt    = '0;
            s_pc_nxt    = '0;
            s_inst_nxt  = '0;
        end else if (!s_valid) begin
            if (!m_valid || out_ready) begin
                m_valid_nxt = acc;
                m_en_nxt    = acc ? in_lane_en : '0;
                m_pc_nxt    = acc ? san_pc : '0;
                m_inst_nxt  = acc ? san_inst : '0;
            end else if (acc) begin
                s_valid_nxt = 1'b1;
                s_en_nxt    = in_lane_en;
                s_pc_nxt    = san_pc;
                s_inst_nxt  = san_inst;
            end
        end else if (out_ready) begin
            m_valid_nxt = s_valid;
            m_en_nxt    = s_en;
            m_pc_nxt    = s_pc;
            m_inst_nxt  = s_inst;
            s_valid_nxt = 1'b0;
            s_en_nxt    = '0;
            s_pc_nxt    = '0;
            s_inst_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_en    <= '0;
            m_pc    <= '0;
            m_inst  <= '0;
            s_valid <= 1'b0;
            s_en    <= '0;
            s_pc    <= '0;
            s_inst  <= '0;
        end else begin
            m_valid <= m_valid_nxt;
            m_en    <= m_en_nxt;
            m_pc    <= m_pc_nxt;
            m_inst  <= m_inst_nxt;
            s_valid <= s_valid_nxt;
            s_en    <= s_en_nxt;
            s_pc    <= s_pc_nxt;
            s_inst  <= s_inst_nxt;
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (m_valid && !out_ready && stall_q != CNT_MAX) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign in_ready    = ~s_valid;
    assign out_valid   = m_valid;
    assign out_lane_en = m_en;
    assign out_pc      = m_pc;
    assign out_inst    = m_inst;
    assign occ         = {1'b0, m_valid} + {1'b0, s_valid};
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage against a FIFO-queue reference model.
module tb_if_id_skid_stage;

    typedef struct packed {
        logic [1:0]  en;
        logic [63:0] pc;
        logic [63:0] inst;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [1:0]  in_lane_en, out_lane_en, occ;
    logic [63:0] in_pc, in_inst, out_pc, out_inst;
    logic [3:0]  stall_cnt;
    logic [137:0] dut_vec;

    int   total = 0;
    int   bad   = 0;
    bun_t mq[$];
    logic [3:0] mcnt;

    always #5 clk = ~clk;

    if_id_skid_stage #(.PC_W(32), .INST_W(32), .LANES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
        .out_pc(out_pc), .out_inst(out_inst), .occ(occ), .stall_cnt(stall_cnt)
    );

    assign dut_vec = {out_valid, occ, in_ready, out_lane_en, out_pc, out_inst, stall_cnt};

    function automatic bun_t sanitize(input logic [1:0] en, input logic [63:0] pc,
                                      input logic [63:0] inst);
        bun_t b;
        b.en = en; b.pc = pc; b.inst = inst;
        for (int i = 0; i < 2; i++) begin
            if (!en[i]) begin
                b.pc[i*32 +: 32]   = '0;
                b.inst[i*32 +: 32] = '0;
            end
        end
        return b;
    endfunction

    function automatic logic [137:0] exp_vec();
        bun_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        return {mq.size() > 0, 2'(mq.size()), mq.size() < 2, h.en, h.pc, h.inst, mcnt};
    endfunction

    // Advance one clock and update the queue model with the inputs seen at the edge
    task automatic tick();
        int  sz;
        bit  c, a;
        @(posedge clk);
        sz = mq.size();
        if (rst) mcnt = 4'd0;
        else if (sz > 0 && !out_ready && mcnt != 4'd15) mcnt = mcnt + 4'd1;
        if (rst || flush) begin
            mq.delete();
        end else begin
            c = (sz > 0) && out_ready;
            a = in_valid && (sz < 2);
            if (c) void'(mq.pop_front());
            if (a) mq.push_back(sanitize(in_lane_en, in_pc, in_inst));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_lane_en = 2'b11; in_pc = 64'hDEAD_BEEF_0000_1111; in_inst = 64'h1234_5678_9ABC_DEF0;
        mcnt = 4'd0;
        tick();
        tick();
        total++;
        if (dut_vec !== {1'b0, 2'd0, 1'b1, 2'b00, 64'd0, 64'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", dut_vec,
                     {1'b0, 2'd0, 1'b1, 2'b00, 64'd0, 64'd0, 4'd0});
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h100 + 32'(k * 8);
            in_valid = 1'b1; in_lane_en = 2'b11;
            in_pc = {pc + 32'd4, pc}; in_inst = {$urandom, $urandom};
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stream_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
            total++;
            if (out_pc[31:0] !== pc || in_ready !== 1'b1 || occ > 2'd1) begin
                bad++;
                $display("FAIL stream_latency k=%0d pc=%h want=%h rdy=%b occ=%0d", k,
                         out_pc[31:0], pc, in_ready, occ);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL stream_drain got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_lane_en = 2'b11; out_ready = 1'b1;
        in_pc = {$urandom, $urandom}; in_inst = {$urandom, $urandom};
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_pc = {$urandom, $urandom}; in_inst = {$urandom, $urandom};
            tick();
            total++;
            if (occ !== 2'd2 || in_ready !== 1'b0 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL skid_fill k=%0d occ=%0d rdy=%b got=%h want=%h", k, occ,
                         in_ready, dut_vec, exp_vec());
            end
        end
        total++;
        if (stall_cnt !== 4'd3) begin
            bad++; $display("FAIL stall_count got=%0d want=3", stall_cnt);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL skid_drain k=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_flush_full();
        in_valid = 1'b1; in_lane_en = 2'b11; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_pc = {$urandom, $urandom}; in_inst = {$urandom, $urandom};
            tick();
        end
        total++;
        if (occ !== 2'd2) begin
            bad++; $display("FAIL flush_prefill occ=%0d want=2", occ);
        end
        flush = 1'b1; in_pc = 64'hAAAA_0004_AAAA_0000;
        tick();
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL flush_full got=%h want=%h", dut_vec, exp_vec());
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL flush_ghost k=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_lane_bubble();
        in_valid = 1'b1; out_ready = 1'b1; in_lane_en = 2'b10;
        in_pc = {32'h204, 32'h200}; in_inst = {32'h1234_5678, 32'h8C01_0004};
        tick();
        total++;
        if (out_lane_en !== 2'b10 || out_pc !== {32'h204, 32'h0} ||
            out_inst !== {32'h1234_5678, 32'h0}) begin
            bad++;
            $display("FAIL lane_bubble en=%b pc=%h inst=%h want en=10 pc=%h inst=%h",
                     out_lane_en, out_pc, out_inst, {32'h204, 32'h0}, {32'h1234_5678, 32'h0});
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        in_valid = 1'b1; in_lane_en = 2'b01; out_ready = 1'b1;
        in_pc = {$urandom, $urandom}; in_inst = {$urandom, $urandom};
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (stall_cnt !== 4'd15) begin
            bad++; $display("FAIL sat_value got=%0d want=15", stall_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (stall_cnt !== 4'd15) begin
            bad++; $display("FAIL sat_flush got=%0d want=15", stall_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (stall_cnt !== 4'd0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL sat_reset cnt=%0d got=%h want=%h", stall_cnt, dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 10000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 99) < 3);
            in_lane_en = 2'($urandom);
            in_pc      = {$urandom, $urandom};
            in_inst    = {$urandom, $urandom};
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                if (errs < 10) $display("FAIL random_model n=%0d got=%h want=%h", n, dut_vec, exp_vec());
                errs++;
            end
            total++;
            if (in_ready !== (occ < 2'd2)) begin
                bad++;
                if (errs < 10) $display("FAIL random_ready n=%0d rdy=%b occ=%0d", n, in_ready, occ);
                errs++;
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_lane_bubble();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
